// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: frame width, legal prescale
// values, FSM state encoding and the majority-vote helper.
package uart_pkg;

    localparam int DATA_W = 8;

    // Index of the last data bit, sized to match bit_cnt.
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    // Legal oversampling ratios (clocks per bit).
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Two-out-of-three vote used to reject single-sample noise.
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Majority-of-3 sampler: captures rx_in on the three clocks around the bit
// centre and flags the decision edge once all three samples are held.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [5:0] edge_cnt,
    input  logic [5:0] prescale,
    output logic       sample_bit,
    output logic       sample_done
);

    logic [5:0] half;
    logic [2:0] samples_q;
    logic [2:0] samples_d;

    assign half = prescale >> 1;

    // Load each sample slot on its own edge around the bit centre.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        samples_d = samples_q;
        if (edge_cnt == half - 6'd1) samples_d[0] = rx_in;
        if (edge_cnt == half)        samples_d[1] = rx_in;
        if (edge_cnt == half + 6'd1) samples_d[2] = rx_in;
    end

    // Sample register; idle-high reset value matches the quiet line.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
        if (!rst) samples_q <= 3'b111;
        else      samples_q <= samples_d;
    end

    assign sample_bit  = maj3(samples_q);
    assign sample_done = (edge_cnt == half + 6'd2);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop FSM, per-bit edge counter,
// LSB-first deserializer and parity/stop checking.
module uart_rx
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic [5:0]        prescale,
    output logic              data_valid,
    output logic              par_error,
    output logic              stp_error,
    output logic [DATA_W-1:0] p_data
);

    uart_state_e       state_q, state_d;
    logic [5:0]        edge_cnt_q, edge_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] p_data_q, p_data_d;
    logic              data_valid_q, data_valid_d;
    logic              par_error_q, par_error_d;
    logic              stp_error_q, stp_error_d;

    logic sample_bit;
    logic sample_done;
    logic end_of_bit;
    logic exp_par;

    uart_rx_sampler u_sampler (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .edge_cnt    (edge_cnt_q),
        .prescale    (prescale),
        .sample_bit  (sample_bit),
        .sample_done (sample_done)
    );

    assign end_of_bit = (edge_cnt_q == prescale - 6'd1);
    // Even parity expects the XOR of the data; odd expects its inverse.
    assign exp_par    = par_typ ? ~^shift_q : ^shift_q;

    // Frame FSM, counters, deserializer and result flags.
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = data_valid_q;
        par_error_d  = par_error_q;
        stp_error_d  = stp_error_q;

        if (state_q != ST_IDLE) begin
            edge_cnt_d = end_of_bit ? 6'd0 : edge_cnt_q + 6'd1;
        end

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = 6'd0;
                bit_cnt_d  = 4'd0;
                // The first low cycle is edge 0 of the start bit.
                if (!rx_in) begin
                    state_d    = ST_START;
                    edge_cnt_d = 6'd1;
                end
            end
            ST_START: begin
                if (sample_done) begin
                    if (sample_bit) begin
                        // Glitch: drop back without touching the outputs.
                        state_d    = ST_IDLE;
                        edge_cnt_d = 6'd0;
                    end else begin
                        data_valid_d = 1'b0;
                        par_error_d  = 1'b0;
                        stp_error_d  = 1'b0;
                    end
                end else if (end_of_bit) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_done) shift_d = {sample_bit, shift_q[DATA_W-1:1]};
                if (end_of_bit) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = 4'd0;
                        state_d   = par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_done) par_error_d = (sample_bit != exp_par);
                if (end_of_bit)  state_d     = ST_STOP;
            end
            ST_STOP: begin
                // Decide at the bit centre and re-arm at once for resync margin.
                if (sample_done) begin
                    stp_error_d = ~sample_bit;
                    if (sample_bit && !par_error_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    state_d    = ST_IDLE;
                    edge_cnt_d = 6'd0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                edge_cnt_d = 6'd0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            edge_cnt_q   <= 6'd0;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_error_q  <= 1'b0;
            stp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_error_q  <= par_error_d;
            stp_error_q  <= stp_error_d;
        end
    end

    assign data_valid = data_valid_q;
    assign par_error  = par_error_q;
    assign stp_error  = stp_error_q;
    assign p_data     = p_data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: each frame pushes its expected result and
// event cycle; a monitor pops and compares when the flags rise.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = PRESCALE_8;
    logic       data_valid;
    logic       par_error;
    logic       stp_error;
    logic [7:0] p_data;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    // Reference model of the held outputs.
    logic       m_dv = 1'b0;
    logic       m_pe = 1'b0;
    logic       m_se = 1'b0;
    logic [7:0] m_pdata = 8'h00;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .data_valid (data_valid),
        .par_error  (par_error),
        .stp_error  (stp_error),
        .p_data     (p_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Called at a negedge; holds the bit for p clocks and returns at a negedge.
    task automatic drive_bit(input logic b, input logic [5:0] p);
        rx_in = b;
        repeat (int'(p)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [5:0] p, input logic [7:0] data, input logic pen,
                              input logic ptyp, input logic bad_par, input logic stop_v,
                              input int gap);
        exp_t e;
        logic par_bit;
        int   h;
        h        = int'(p) / 2;
        prescale = p;
        par_en   = pen;
        par_typ  = ptyp;
        e.pe     = pen && bad_par;
        e.se     = !stop_v;
        e.dv     = !e.pe && !e.se;
        e.data   = e.dv ? data : m_pdata;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(data[i], p);
        if (pen) begin
            par_bit = (ptyp ? ~^data : ^data) ^ bad_par;
            if (e.pe) begin
                e.cyc = cyc + h + 3;
                sb.push_back(e);
            end
            drive_bit(par_bit, p);
        end
        if (!e.pe) begin
            e.cyc = cyc + h + 3;
            sb.push_back(e);
        end
        drive_bit(stop_v, p);
        rx_in = 1'b1;
        repeat (gap) @(negedge clk);
        m_dv = e.dv;
        m_pe = e.pe;
        m_se = e.se;
        m_pdata = e.data;
    endtask

    // Monitor: a 0 -> nonzero change of the flags is one frame result.
    initial begin : monitor
        logic [2:0] flags;
        logic [2:0] prev;
        exp_t       e;
        prev = 3'b000;
        forever begin
            @(negedge clk);
            flags = {data_valid, par_error, stp_error};
            if (rst && flags != 3'b000 && prev == 3'b000) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(flags), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("data_valid", 32'(data_valid), 32'(e.dv));
                    check("par_error",  32'(par_error),  32'(e.pe));
                    check("stp_error",  32'(stp_error),  32'(e.se));
                    check("p_data",     32'(p_data),     32'(e.data));
                    check("event_cycle", 32'(cyc),       32'(e.cyc));
                end
            end
            prev = flags;
        end
    end

    initial begin : stimulus
        logic [5:0] p;
        repeat (3) @(negedge clk);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_par_error",  32'(par_error),  32'd0);
        check("rst_stp_error",  32'(stp_error),  32'd0);
        check("rst_p_data",     32'(p_data),     32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Main function over the three prescales and both parity senses.
        send_frame(PRESCALE_8,  8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8);
        send_frame(PRESCALE_16, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        send_frame(PRESCALE_32, 8'h49, 1'b0, 1'b0, 1'b0, 1'b1, 32);
        send_frame(PRESCALE_32, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 32);

        // Back-to-back frames with no idle gap.
        send_frame(PRESCALE_8, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        send_frame(PRESCALE_8, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8);

        // Error frames: wrong parity, then stop bit low.
        send_frame(PRESCALE_8,  8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8);
        send_frame(PRESCALE_16, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 32);

        // Random good frames.
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 2))
                0:       p = PRESCALE_8;
                1:       p = PRESCALE_16;
                default: p = PRESCALE_32;
            endcase
            send_frame(p, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b0, 1'b1, int'(p));
        end

        send_frame(PRESCALE_16, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 16);

        // Two-clock start glitch must leave outputs untouched.
        prescale = PRESCALE_16;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (48) @(negedge clk);
        check("glitch_data_valid", 32'(data_valid), 32'(m_dv));
        check("glitch_par_error",  32'(par_error),  32'(m_pe));
        check("glitch_stp_error",  32'(stp_error),  32'(m_se));
        check("glitch_p_data",     32'(p_data),     32'(m_pdata));
        send_frame(PRESCALE_8, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 8);

        // Reset in the middle of a frame.
        prescale = PRESCALE_8;
        par_en   = 1'b0;
        drive_bit(1'b0, PRESCALE_8);
        drive_bit(1'b1, PRESCALE_8);
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx_in = 1'b1;
        #1;
        check("midrst_data_valid", 32'(data_valid), 32'd0);
        check("midrst_par_error",  32'(par_error),  32'd0);
        check("midrst_stp_error",  32'(stp_error),  32'd0);
        check("midrst_p_data",     32'(p_data),     32'd0);
        m_dv = 1'b0;
        m_pe = 1'b0;
        m_se = 1'b0;
        m_pdata = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        send_frame(PRESCALE_8, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
